// File: rtl/fft_ctrl.sv
// Address/strobe sequencer for one shared radix-2 DIF butterfly over an in-place
// N-point memory. Strobes are registered; write-back follows reads by two cycles.
module fft_ctrl #(
    parameter int LOG2N  = 8,
    parameter int ADDR_W = LOG2N,
    parameter int TW_W   = LOG2N - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [LOG2N-1:0]  stage,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [TW_W-1:0]   tw_addr,
    output logic              bf_enable,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FINISH = 2'd3} state_t;

    localparam int KW = LOG2N - 1;
    localparam logic [KW-1:0]    K_LAST = '1;
    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [LOG2N-1:0]  s_q, s_d;
    logic              dcnt_q, dcnt_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d, rd_addr_b_q, rd_addr_b_d;
    logic [TW_W-1:0]   tw_addr_q, tw_addr_d;
    logic              bf_en_q, bf_en_d;
    logic              wr_en_p1_q, wr_en_p1_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wa_p1_q, wa_p1_d, wb_p1_q, wb_p1_d;
    logic [ADDR_W-1:0] wr_addr_a_q, wr_addr_a_d, wr_addr_b_q, wr_addr_b_d;
    logic [ADDR_W-1:0] kx, hi_sh, span, jx, ax;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    k_d     = '0;
                    s_d     = '0;
                end
            end
            RUN: begin
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    k_d     = '0;
                    dcnt_d  = 1'b0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                if (dcnt_q) begin
                    if (s_q != S_LAST) begin
                        s_d     = s_q + LOG2N'(1);
                        state_d = RUN;
                    end else begin
                        state_d = FINISH;
                    end
                end else begin
                    dcnt_d = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        // Group base = (k >> log2(span)) << log2(2*span); offset j = k mod span.
        kx    = ADDR_W'(k_d);
        hi_sh = ADDR_W'(S_LAST - s_d);
        span  = ADDR_W'(1) << hi_sh;
        jx    = kx & (span - ADDR_W'(1));
        ax    = ((kx >> hi_sh) << (hi_sh + ADDR_W'(1))) | jx;

        rd_en_d     = (state_d == RUN);
        rd_addr_a_d = rd_en_d ? ax : '0;
        rd_addr_b_d = rd_en_d ? (ax | span) : '0;
        tw_addr_d   = rd_en_d ? (TW_W'(jx) << s_d) : '0;
        busy_d      = (state_d == RUN) || (state_d == DRAIN);
        done_d      = (state_d == FINISH);

        // Free-running delay line matching the butterfly and memory latency.
        bf_en_d     = rd_en_q;
        wr_en_p1_d  = rd_en_q;
        wa_p1_d     = rd_addr_a_q;
        wb_p1_d     = rd_addr_b_q;
        wr_en_d     = wr_en_p1_q;
        wr_addr_a_d = wa_p1_q;
        wr_addr_b_d = wb_p1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            s_q         <= '0;
            dcnt_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_addr_q   <= '0;
            bf_en_q     <= 1'b0;
            wr_en_p1_q  <= 1'b0;
            wa_p1_q     <= '0;
            wb_p1_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            s_q         <= s_d;
            dcnt_q      <= dcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_addr_q   <= tw_addr_d;
            bf_en_q     <= bf_en_d;
            wr_en_p1_q  <= wr_en_p1_d;
            wa_p1_q     <= wa_p1_d;
            wb_p1_q     <= wb_p1_d;
            wr_en_q     <= wr_en_d;
            wr_addr_a_q <= wr_addr_a_d;
            wr_addr_b_q <= wr_addr_b_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign stage     = s_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign tw_addr   = tw_addr_q;
    assign bf_enable = bf_en_q;
    assign wr_en     = wr_en_q;
    assign wr_addr_a = wr_addr_a_q;
    assign wr_addr_b = wr_addr_b_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_ctrl.sv
// Bench for fft_ctrl: an N=8 and an N=256 instance checked cycle-exactly against
// expected read/write/done events queued when each start is issued.
module tb_fft_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start3 = 1'b0, start8 = 1'b0;
    logic sel = 1'b0;
    int   cyc = 0;

    logic       busy3, done3, rd_en3, bf3, wr_en3;
    logic [2:0] stage3, ra3, rb3, wa3, wb3;
    logic [1:0] tw3, dbg3;

    logic       busy8, done8, rd_en8, bf8, wr_en8;
    logic [7:0] stage8, ra8, rb8, wa8, wb8;
    logic [6:0] tw8;
    logic [1:0] dbg8;

    fft_ctrl #(.LOG2N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
        .stage(stage3), .rd_en(rd_en3), .rd_addr_a(ra3), .rd_addr_b(rb3),
        .tw_addr(tw3), .bf_enable(bf3), .wr_en(wr_en3), .wr_addr_a(wa3),
        .wr_addr_b(wb3), .dbg_state(dbg3)
    );

    fft_ctrl #(.LOG2N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
        .stage(stage8), .rd_en(rd_en8), .rd_addr_a(ra8), .rd_addr_b(rb8),
        .tw_addr(tw8), .bf_enable(bf8), .wr_en(wr_en8), .wr_addr_a(wa8),
        .wr_addr_b(wb8), .dbg_state(dbg8)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // scoreboard
    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] exp_rd_q[$];
    logic [63:0] exp_wr_q[$];
    logic [63:0] exp_bf_q[$];
    logic [63:0] exp_done_q[$];
    int busy_from = 0, busy_to = -1;
    int n_done3 = 0, n_wr8 = 0, n_rd8 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pack(int st, int c, int a, int b, int t);
        return {8'(st), 20'(c), 12'(a), 12'(b), 12'(t)};
    endfunction

    // Expected events of one full transform whose start is sampled at the edge
    // following the negedge where cyc == base; cycle n of the run has cyc == base+n.
    task automatic push_run(input int base, input int l2);
        int n = 1 << l2;
        int h = n / 2;
        for (int s = 0; s < l2; s++) begin
            int span = n >> (s + 1);
            for (int g = 0; g < h / span; g++) begin
                for (int j = 0; j < span; j++) begin
                    int c = base + 1 + s * (h + 2) + g * span + j;
                    int a = 2 * g * span + j;
                    int t = (j << s) % h;
                    exp_rd_q.push_back(pack(s, c, a, a + span, t));
                    exp_bf_q.push_back(pack(0, c + 1, 0, 0, 0));
                    exp_wr_q.push_back(pack(0, c + 2, a, a + span, 0));
                end
            end
        end
        exp_done_q.push_back(pack(0, base + l2 * (h + 2) + 1, 0, 0, 0));
        busy_from = base + 1;
        busy_to   = base + l2 * (h + 2);
    endtask

    // monitor: observed signals of the selected instance
    logic        m_rd_en, m_bf, m_wr_en, m_busy, m_done;
    logic [7:0]  m_stage;
    logic [11:0] m_ra, m_rb, m_tw, m_wa, m_wb;
    assign m_rd_en = sel ? rd_en8 : rd_en3;
    assign m_bf    = sel ? bf8 : bf3;
    assign m_wr_en = sel ? wr_en8 : wr_en3;
    assign m_busy  = sel ? busy8 : busy3;
    assign m_done  = sel ? done8 : done3;
    assign m_stage = sel ? stage8 : 8'(stage3);
    assign m_ra    = sel ? 12'(ra8) : 12'(ra3);
    assign m_rb    = sel ? 12'(rb8) : 12'(rb3);
    assign m_tw    = sel ? 12'(tw8) : 12'(tw3);
    assign m_wa    = sel ? 12'(wa8) : 12'(wa3);
    assign m_wb    = sel ? 12'(wb8) : 12'(wb3);

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_rd_en) begin
                if (sel) n_rd8++;
                if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd", pack(int'(m_stage), cyc, int'(m_ra), int'(m_rb), int'(m_tw)),
                         exp_rd_q.pop_front());
            end
            if (m_bf) begin
                if (exp_bf_q.size() == 0) chk("bf_unexpected", 1, 0);
                else chk("bf", pack(0, cyc, 0, 0, 0), exp_bf_q.pop_front());
            end
            if (m_wr_en) begin
                if (sel) n_wr8++;
                if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("wr", pack(0, cyc, int'(m_wa), int'(m_wb), 0), exp_wr_q.pop_front());
            end
            if (m_done) begin
                if (!sel) n_done3++;
                if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done", pack(0, cyc, 0, 0, 0), exp_done_q.pop_front());
            end
            chk("busy", 64'(m_busy), 64'(cyc >= busy_from && cyc <= busy_to));
        end
    end

    // driver tasks (called at a negedge, return at a negedge)
    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_start(input bit accept, output int base);
        base = cyc;
        if (sel) start8 = 1'b1; else start3 = 1'b1;
        if (accept) push_run(cyc, sel ? 8 : 3);
        @(negedge clk);
        start3 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_n8"}, 64'({busy3, done3, rd_en3, bf3, wr_en3, stage3, ra3, rb3, tw3, wa3, wb3, dbg3}), 0);
        chk({tag, "_n256"}, 64'({busy8, done8, rd_en8, bf8, wr_en8, stage8, ra8, rb8, tw8, wa8, wb8, dbg8}), 0);
    endtask

    initial begin
        int b, b2, dummy;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single run with ignored re-pulses at cycles 5 and 19, restart at 20
        pulse_start(1'b1, b);
        wait_until(b + 5);
        pulse_start(1'b0, dummy);
        wait_until(b + 19);
        pulse_start(1'b0, dummy);
        wait_until(b + 20);
        pulse_start(1'b1, b2);
        wait_until(b2 + 24);

        // start held high: re-triggers only once the FSM is back in IDLE
        b = cyc;
        start3 = 1'b1;
        push_run(cyc, 3);
        wait_until(b + 20);
        push_run(cyc, 3);
        wait_until(b + 25);
        start3 = 1'b0;
        wait_until(b + 20 + 24);

        // asynchronous reset in cycle 9 of a run
        pulse_start(1'b1, b);
        wait_until(b + 9);
        #1 rst_n = 1'b0;
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_bf_q.delete();
        exp_done_q.delete();
        busy_to = -1;
        #1 check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        // recovery run after reset
        pulse_start(1'b1, b);
        wait_until(b + 24);

        // N = 256 full transform
        sel = 1'b1;
        @(negedge clk);
        pulse_start(1'b1, b);
        wait_until(b + 1041 + 4);

        chk("n256_reads", n_rd8, 1024);
        chk("n256_writes", n_wr8, 1024);
        chk("n8_done_count", n_done3, 5);
        chk("rd_q_left", exp_rd_q.size(), 0);
        chk("wr_q_left", exp_wr_q.size(), 0);
        chk("bf_q_left", exp_bf_q.size(), 0);
        chk("done_q_left", exp_done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_ctrl.md
Name: fft_ctrl

Overview:
- Sequencer for one shared radix-2 DIF butterfly over an in-place N-point sample memory. The butterfly has 1-cycle registered latency and computes Xa = a+b, Xb = (a-b)*W.
- On start, the block walks LOG2N stages and issues one butterfly per cycle. For each butterfly it generates the memory read addresses, the twiddle-ROM address, the butterfly enable, and write-back addresses and strobes delayed to match the pipeline.
- Between stages it drains the pipeline to avoid read-after-write hazards.

Parameters:
- LOG2N, 8, log2 of FFT size N (N = 2**LOG2N). Valid range 2..12.
- ADDR_W, LOG2N, sample memory address width.
- TW_W, LOG2N-1, twiddle ROM address width (ROM holds N/2 entries).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle request to run a full FFT. Ignored while busy.
- busy  out  1  high while a transform is in progress.
- done  out  1  1-cycle pulse when the final write-back is issued-complete.
- stage  out  LOG2N bits  current stage index 0..LOG2N-1 (read side).
- rd_en  out  1  memory read strobe. Sync memory with 1-cycle read latency.
- rd_addr_a  out  ADDR_W  read address of operand a.
- rd_addr_b  out  ADDR_W  read address of operand b.
- tw_addr  out  TW_W  twiddle ROM address. Issued with rd_en; ROM has 1-cycle latency.
- bf_enable  out  1  butterfly enable, equal to rd_en delayed 1 cycle.
- wr_en  out  1  write strobe, equal to rd_en delayed 2 cycles.
- wr_addr_a  out  ADDR_W  rd_addr_a delayed 2 cycles.
- wr_addr_b  out  ADDR_W  rd_addr_b delayed 2 cycles.

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE. All outputs and the delay pipeline clear to 0. Reset mid-transform aborts immediately; no further strobes are issued after release.
- FSM states are IDLE, RUN, DRAIN, FINISH.
- IDLE: start=1 sampled on an edge → RUN, with stage=0 and butterfly counter k=0. busy goes high the same edge.
- RUN: each cycle, rd_en=1 with addresses computed from stage s and k:
  - span = N >> (s+1); j = k mod span; g = k div span.
  - rd_addr_a = 2*g*span + j; rd_addr_b = rd_addr_a + span.
  - tw_addr = j << s, truncated to TW_W.
  - k increments each cycle. At k = N/2-1 → DRAIN, and k clears.
- DRAIN: exactly 2 cycles with rd_en=0, so the last write of the stage commits before the next stage reads.
  - If s < LOG2N-1: s increments, then → RUN.
  - Otherwise → FINISH.
- FINISH: one cycle. done=1, busy=0 on the same cycle; next state is IDLE.
- busy is high from the cycle after start is sampled through the last DRAIN cycle.
- Delay pipeline is free-running: bf_enable, wr_en and wr_addr_a/b follow rd_en and rd_addr_a/b by exactly 1 and 2 cycles, independent of FSM state.
- Timing, with cycle 1 = first cycle after the start edge:
  - Stage s reads occupy cycles 1 + s*(N/2+2) through s*(N/2+2) + N/2.
  - done is high in cycle LOG2N*(N/2+2) + 1.
- start asserted during busy or FINISH is ignored; it is not queued.
- start held high continuously re-triggers only from IDLE.
- Twiddle convention: ROM index m holds W_N^m. The last stage always uses m=0.

Test Plan:
- LOG2N=3, start pulse → reads in cycles 1-4 are (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3. Cycles 5-6 have rd_en=0. Cycles 7-10 are (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2. Cycles 13-16 are (0,1),(2,3),(4,5),(6,7) with tw 0.
- LOG2N=3 pipeline check → bf_enable high in cycles 2-5, 8-11 and 14-17. wr_en high in cycles 3-6, 9-12 and 15-18, with wr_addr equal to read addresses 2 cycles earlier. done high only in cycle 19, and busy falls in cycle 19.
- Hazard check with LOG2N=3 → no cycle has rd_en=1 while wr_en=1 carries a previous-stage address. The last write of each stage occurs in the cycle before the next stage's first read.
- start re-pulsed at cycle 5 and at cycle 19 → no effect on the sequence; done count stays 1. A start at cycle 20 (IDLE) → a new run begins, with reads at cycle 21.
- rst_n asserted at cycle 9, then released → all outputs 0 asynchronously and the FSM returns to IDLE. No wr_en pulses appear after release until a new start.
- LOG2N=8 full run → 1024 butterflies total. done is high in cycle 8*(128+2)+1 = 1041. Every address 0..255 is written exactly once per stage.
